fpu_result_serializer: RTL and testbench
========================================

// Module: fpu_result_serializer
// PURPOSE
//  Transmit side of the FPU pin interface. Operands arrive on ui_in; this block
//  returns the FPU result, which is wider than the 8-bit output pins. It accepts
//  one RES_WIDTH-bit result via valid/ready, then presents it one byte at a time
//  on uo_out. The host paces the bytes with an acknowledge pin on uio_in.
// PARAMETERS
//  RES_WIDTH  16  result width in bits; must be a multiple of 8 and >= 16
//  MSB_FIRST  1   1: send the most significant byte first; 0: send the LSB first
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          asynchronous reset, active-low
//  ena         in   1          design enable; 0 freezes the block
//  res_data    in   RES_WIDTH  FPU result word
//  res_valid   in   1          res_data is valid
//  res_ready   out  1          block can accept a result
//  byte_out    out  8          current result byte (drives uo_out)
//  byte_valid  out  1          byte_out holds a valid byte (drives a uio_out bit)
//  last_byte   out  1          byte_out is the final byte of the word
//  byte_ack    in   1          raw host acknowledge pin (from uio_in); asynchronous
//  busy        out  1          a transfer is in progress
// BEHAVIOUR
//  - One clock domain: clk. Reset is asynchronous and active-low (rst_n).
//  - NB = RES_WIDTH/8. Byte index idx counts 0..NB-1.
//  - Reset values: state=IDLE, shift register=0, idx=0, ack synchroniser=0.
//    byte_out=8'h00, byte_valid=0, last_byte=0, busy=0.
//    res_ready = ena (it is combinational; see below).
//  - Ack path:
//    - byte_ack passes through a 2-flop synchroniser, then a rising-edge
//      detector: ack_rise = s2 & ~s3.
//    - The detector runs regardless of state and ena.
//    - ack_rise is consumed only in SEND with ena=1; in every other case it is dropped.
//  - State IDLE:
//    - res_ready = ena (combinational); byte_valid=0, byte_out=8'h00, busy=0.
//    - Capture: at a clock edge with res_valid & res_ready, latch res_data, set
//      idx=0 and go to SEND.
//    - No combinational path from res_valid to res_ready.
//  - State SEND:
//    - res_ready=0, busy=1, byte_valid=1.
//    - byte_out = byte idx of the word, taken from the MSB end when MSB_FIRST=1,
//      else from the LSB end. last_byte = (idx==NB-1).
//    - On a clock edge with ena & ack_rise:
//      - idx<NB-1: idx+1, and the next byte appears the following cycle.
//      - idx==NB-1: go to IDLE; byte_valid/busy drop and res_ready rises next cycle.
//    - res_valid is ignored while in SEND.
//  - Latency:
//    - Capture edge N gives the first byte valid from cycle N+1.
//    - Ack pin high, first sampled at edge K, advances the byte at edge K+2.
//      byte_out changes after edge K+2, i.e. 3 edges counting K.
//  - A host must drop byte_ack and raise it again for every byte.
//    - An ack held high across the transition into SEND is not an edge and does
//      not advance.
//    - An ack pulse shorter than one clk period may be missed.
//  - ena=0: state, idx and the shift register hold; outputs hold their values.
//    res_ready=0. Ack edges that occur while ena=0 are lost.
//  - Back-to-back words: after the last ack, IDLE lasts at least 1 cycle before
//    the next capture. There are no gaps or duplicated bytes across words.
//  - rst_n low mid-transfer aborts immediately. The remaining bytes are
//    discarded and all outputs go to their reset values.
// TESTING
//  - Reset/idle: rst_n=0 then 1, ena=1 -> byte_valid=0, byte_out=00, busy=0,
//    res_ready=1. Ack toggling in IDLE has no effect.
//  - MSB_FIRST=1, RES_WIDTH=16:
//    - Send res_data=16'h3C00; expect byte_out=3C, last_byte=0 from N+1.
//    - Ack pulse: byte_out=00, last_byte=1.
//    - Second ack pulse: byte_valid=0, res_ready=1.
//  - MSB_FIRST=0, RES_WIDTH=32, word 32'h4049_0FDB: bytes DB,0F,49,40 in that
//    order, last_byte only on 40. Exactly 4 ack edges are consumed.
//  - Held ack: keep byte_ack=1 through capture -> byte stays at idx 0 until the
//    pin falls and rises again. A 2-cycle ack high advances exactly one byte.
//  - ena=0 mid-word: outputs freeze and res_ready=0. An ack pulse during ena=0
//    does not advance. After ena=1 the next ack advances one byte.
//  - Reset mid-word after byte 0 is acked: all outputs go to their reset values.
//    A new word 16'hABCD then streams AB,CD correctly.

Source files
------------

// File: rtl/fpu_result_serializer.sv
// Result serializer for the FPU pin interface: takes one RES_WIDTH-bit result by
// valid/ready and returns it a byte at a time, with each byte released by a host ack edge.
module fpu_result_serializer #(
   parameter int RES_WIDTH = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [RES_WIDTH-1:0] res_data,
   input  logic                 res_valid,
   output logic                 res_ready,
   output logic [7:0]           byte_out,
   output logic                 byte_valid,
   output logic                 last_byte,
   input  logic                 byte_ack,
   output logic                 busy
);

   localparam int NB    = RES_WIDTH / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t               state_reg, state_next;
   logic [RES_WIDTH-1:0] shift_reg, shift_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [2:0]           ack_sync_reg;
   logic                 ack_rise;
   logic [7:0]           head_byte;
   logic [RES_WIDTH-1:0] shifted_word;

   // The outgoing byte always sits at the head of the shift register, so an advance is one shift.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign head_byte    = shift_reg[RES_WIDTH-1 -: 8];
         assign shifted_word = shift_reg << 8;
      end else begin : g_lsb_first
         assign head_byte    = shift_reg[7:0];
         assign shifted_word = shift_reg >> 8;
      end
   endgenerate

   // Bits [1:0] synchronise the raw pin; bit [2] is the previous synchronised value.
   assign ack_rise = ack_sync_reg[1] & ~ack_sync_reg[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync_reg <= 3'b000;
      end else begin
         ack_sync_reg <= {ack_sync_reg[1:0], byte_ack};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      idx_next   = idx_reg;
      res_ready  = 1'b0;
      byte_out   = 8'h00;
      byte_valid = 1'b0;
      last_byte  = 1'b0;
      busy       = 1'b0;

      case (state_reg)
         IDLE: begin
            res_ready = ena;
            if (ena && res_valid) begin
               shift_next = res_data;
               idx_next   = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            busy       = 1'b1;
            byte_valid = 1'b1;
            byte_out   = head_byte;
            last_byte  = (idx_reg == LAST_IDX);
            if (ena && ack_rise) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  shift_next = shifted_word;
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_fpu_result_serializer.sv
// Scoreboard bench for fpu_result_serializer: a 16-bit MSB-first and a 32-bit LSB-first
// instance, with expected bytes queued at issue and checked when the host acks each byte.
module tb_fpu_result_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ena;
   logic [15:0] data16;
   logic        valid16, ready16, bv16, last16, ack16, busy16;
   logic [7:0]  bo16;
   logic [31:0] data32;
   logic        valid32, ready32, bv32, last32, ack32, busy32;
   logic [7:0]  bo32;

   int vectors     = 0;
   int miscompares = 0;

   logic [8:0] q16[$];
   logic [8:0] q32[$];
   logic [8:0] e16, e32;
   logic       ap16 = 1'b0;
   logic       ap32 = 1'b0;

   fpu_result_serializer #(.RES_WIDTH(16), .MSB_FIRST(1'b1)) u16 (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .res_data(data16), .res_valid(valid16), .res_ready(ready16),
      .byte_out(bo16), .byte_valid(bv16), .last_byte(last16),
      .byte_ack(ack16), .busy(busy16)
   );

   fpu_result_serializer #(.RES_WIDTH(32), .MSB_FIRST(1'b0)) u32 (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .res_data(data32), .res_valid(valid32), .res_ready(ready32),
      .byte_out(bo32), .byte_valid(bv32), .last_byte(last32),
      .byte_ack(ack32), .busy(busy32)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte i of the transmit order: counted from the top of the word when msb is set.
   function automatic logic [7:0] ref_byte(input logic [31:0] w, input int nb, input bit msb,
                                           input int i);
      int pos;
      pos = msb ? (nb - 1 - i) : i;
      return 8'((w >> (8 * pos)) & 32'hFF);
   endfunction

   // {res_ready, byte_valid, last_byte, busy, byte_out}
   function automatic logic [11:0] status(input bit sel);
      if (sel) return {ready32, bv32, last32, busy32, bo32};
      return {ready16, bv16, last16, busy16, bo16};
   endfunction

   function automatic logic get_ready(input bit sel);
      return sel ? ready32 : ready16;
   endfunction

   task automatic set_ack(input bit sel, input logic v);
      if (sel) ack32 = v;
      else     ack16 = v;
   endtask

   task automatic send_word(input bit sel, input logic [31:0] word);
      int nb;
      int n;
      nb = sel ? 4 : 2;
      for (int i = 0; i < nb; i++) begin
         if (sel) q32.push_back({1'(i == nb - 1), ref_byte(word, nb, 1'b0, i)});
         else     q16.push_back({1'(i == nb - 1), ref_byte(word, nb, 1'b1, i)});
      end
      @(posedge clk); #1;
      if (sel) begin data32 = word; valid32 = 1'b1; end
      else begin data16 = word[15:0]; valid16 = 1'b1; end
      n = 0;
      @(negedge clk);
      while (!get_ready(sel) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check(sel ? "ready_timeout32" : "ready_timeout16", 32'(get_ready(sel)), 1);
      @(posedge clk); #1;
      if (sel) valid32 = 1'b0;
      else     valid16 = 1'b0;
   endtask

   task automatic ack_pulse(input bit sel, input int hi, input int lo);
      @(posedge clk); #1;
      set_ack(sel, 1'b1);
      repeat (hi) @(posedge clk);
      #1;
      set_ack(sel, 1'b0);
      repeat (lo) @(posedge clk);
   endtask

   // A rising ack while enabled is the host taking the presented byte.
   always @(negedge clk) begin
      if (ack16 && !ap16 && ena && rst_n && (bv16 || q16.size() > 0)) begin
         if (q16.size() == 0) begin
            check("dut16_unexpected_byte", 32'(bv16), 0);
         end else begin
            e16 = q16.pop_front();
            check("dut16_valid", 32'(bv16), 1);
            check("dut16_byte", 32'(bo16), 32'(e16[7:0]));
            check("dut16_last", 32'(last16), 32'(e16[8]));
         end
      end
      ap16 <= ack16;
   end

   always @(negedge clk) begin
      if (ack32 && !ap32 && ena && rst_n && (bv32 || q32.size() > 0)) begin
         if (q32.size() == 0) begin
            check("dut32_unexpected_byte", 32'(bv32), 0);
         end else begin
            e32 = q32.pop_front();
            check("dut32_valid", 32'(bv32), 1);
            check("dut32_byte", 32'(bo32), 32'(e32[7:0]));
            check("dut32_last", 32'(last32), 32'(e32[8]));
         end
      end
      ap32 <= ack32;
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1;
      data16 = '0; valid16 = 1'b0; ack16 = 1'b0;
      data32 = '0; valid32 = 1'b0; ack32 = 1'b0;

      // Reset and idle behaviour
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_reset16", 32'(status(0)), 32'h800);
      check("in_reset32", 32'(status(1)), 32'h800);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle16", 32'(status(0)), 32'h800);
      check("idle32", 32'(status(1)), 32'h800);
      ack_pulse(0, 2, 3);
      ack_pulse(1, 2, 3);
      @(negedge clk);
      check("idle_ack16", 32'(status(0)), 32'h800);
      check("idle_ack32", 32'(status(1)), 32'h800);

      // 16-bit MSB-first word with exact ack latency
      send_word(0, 32'h3C00);
      @(negedge clk);
      check("first_byte16", 32'(status(0)), 32'h53C);
      @(posedge clk); #1;
      ack16 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("lat_hold16", 32'(status(0)), 32'h53C);
      @(posedge clk);
      @(negedge clk);
      check("lat_adv16", 32'(status(0)), 32'h700);
      @(posedge clk); #1;
      ack16 = 1'b0;
      repeat (3) @(posedge clk);
      ack_pulse(0, 2, 3);
      @(negedge clk);
      check("done16", 32'(status(0)), 32'h800);

      // 32-bit LSB-first word: DB,0F,49,40 then a surplus ack
      send_word(1, 32'h4049_0FDB);
      repeat (4) ack_pulse(1, 2, 3);
      @(negedge clk);
      check("done32", 32'(status(1)), 32'h800);
      ack_pulse(1, 2, 3);
      @(negedge clk);
      check("surplus_ack32", 32'(status(1)), 32'h800);
      check("q32_empty_a", 32'(q32.size()), 0);

      // Ack held high through capture is not an edge
      @(posedge clk); #1;
      ack16 = 1'b1;
      repeat (3) @(posedge clk);
      send_word(0, 32'hBEEF);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("held_idx0", 32'(status(0)), 32'h5BE);
      @(posedge clk); #1;
      ack16 = 1'b0;
      repeat (3) @(posedge clk);
      ack_pulse(0, 2, 3);
      @(negedge clk);
      check("held_one_adv", 32'(status(0)), 32'h7EF);
      ack_pulse(0, 2, 3);
      @(negedge clk);
      check("held_done", 32'(status(0)), 32'h800);

      // ena=0 mid-word freezes outputs and loses ack edges
      send_word(1, 32'h1122_3344);
      ack_pulse(1, 2, 3);
      @(posedge clk); #1;
      ena = 1'b0;
      @(negedge clk);
      check("ena0_freeze32", 32'(status(1)), 32'h533);
      check("ena0_ready16", 32'(status(0)), 32'h000);
      ack_pulse(1, 2, 3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ena0_no_adv32", 32'(status(1)), 32'h533);
      @(posedge clk); #1;
      ena = 1'b1;
      ack_pulse(1, 2, 3);
      @(negedge clk);
      check("ena_resume32", 32'(status(1)), 32'h522);
      repeat (2) ack_pulse(1, 2, 3);
      @(negedge clk);
      check("ena_done32", 32'(status(1)), 32'h800);

      // Reset mid-word aborts; the next word streams cleanly
      send_word(0, 32'h5A69);
      ack_pulse(0, 2, 3);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid16", 32'(status(0)), 32'h800);
      q16.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_word(0, 32'hABCD);
      repeat (2) ack_pulse(0, 2, 3);
      @(negedge clk);
      check("after_rst16", 32'(status(0)), 32'h800);

      // Randomised words, ack widths, idle gaps and ena drops
      for (int w = 0; w < 30; w++) begin
         bit sel;
         int nb;
         sel = 1'($urandom_range(0, 1));
         nb  = sel ? 4 : 2;
         send_word(sel, $urandom);
         for (int b = 0; b < nb; b++) begin
            ack_pulse(sel, $urandom_range(1, 3), $urandom_range(3, 5));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
               ena = 1'b0;
               repeat ($urandom_range(1, 4)) @(posedge clk);
               #1;
               ena = 1'b1;
            end
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      @(negedge clk);
      check("rand_idle16", 32'(status(0)), 32'h800);
      check("rand_idle32", 32'(status(1)), 32'h800);
      check("q16_empty", 32'(q16.size()), 0);
      check("q32_empty", 32'(q32.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
